// File: rtl/wallace_final_adder.sv
// -----------------------------------------------------------------------------
// wallace_final_adder
//
// Final carry-propagate stage of the 32x32 Wallace multiplier. It resolves the
// redundant sum/carry pair left by the CSA tree into the WIDTH-bit product,
// adding one CHUNK-bit slice per cycle. The reservation-station tag travels
// with the operands.
//
// Parameters
//   WIDTH  product width (integer multiple of CHUNK)
//   CHUNK  bits resolved per cycle; N = WIDTH/CHUNK ADD cycles per operation
//   TAG_W  reservation-station tag width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous squash, drops any operation in flight
//   in_valid     sum/carry pair offered
//   in_ready     block can accept (high only in IDLE)
//   in_sum       CSA sum vector
//   in_carry     CSA carry vector (bit 0 not assumed zero)
//   in_tag       tag of the producing instruction
//   out_valid    product valid
//   out_ready    consumer accepts
//   out_product  in_sum + in_carry mod 2^WIDTH
//   out_tag      tag captured with the operands
//   busy         state != IDLE
//   out_ovf      (WALLACE_FA_OVF_EN only) carry out of the top chunk
//
// Build option
//   WALLACE_FA_OVF_EN  adds out_ovf; when undefined the top carry is dropped.
// -----------------------------------------------------------------------------
module wallace_final_adder #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
`ifdef WALLACE_FA_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Reject configurations where the slices would not tile the product
   if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_cfg
      $error("wallace_final_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_carry;
   logic [WIDTH-1:0] r_result;
   logic [TAG_W-1:0] r_tag;
   logic [IDX_W-1:0] r_idx;
   logic             r_c;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
`ifdef WALLACE_FA_OVF_EN
   logic             r_ovf;
`endif

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   logic [1:0]       w_state_nxt;
   logic             w_accept;
   logic             w_add_step;
   logic             w_last;
   logic [CHUNK-1:0] w_chunk_res;
   logic             w_chunk_cout;

   // One slice add: the low chunk of the shifted operand registers plus the
   // carry from the previous slice.
   always_comb begin
      {w_chunk_cout, w_chunk_res} = {1'b0, r_sum[CHUNK-1:0]}
                                  + {1'b0, r_carry[CHUNK-1:0]}
                                  + (CHUNK+1)'(r_c);
   end

   // Next-state and handshake decode; flush overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_add_step  = 1'b0;
      w_last      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_state_nxt = S_ADD;
               w_accept    = 1'b1;
            end
         end
         S_ADD: begin
            w_add_step = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (flush) begin
         w_state_nxt = S_IDLE;
         w_accept    = 1'b0;
         w_add_step  = 1'b0;
         w_last      = 1'b0;
      end
   end

   // State register plus registered state decodes for the handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Datapath. The operand registers shift right one chunk per ADD cycle so
   // the adder always reads bit 0 upward; each resolved chunk enters the top
   // of r_result, which is fully aligned after N cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum    <= '0;
         r_carry  <= '0;
         r_result <= '0;
         r_tag    <= '0;
         r_idx    <= '0;
         r_c      <= 1'b0;
`ifdef WALLACE_FA_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_sum   <= in_sum;
         r_carry <= in_carry;
         r_tag   <= in_tag;
         r_idx   <= '0;
         r_c     <= 1'b0;
      end else if (w_add_step) begin
         r_sum    <= r_sum >> CHUNK;
         r_carry  <= r_carry >> CHUNK;
         r_result <= (r_result >> CHUNK)
                   | (WIDTH'(w_chunk_res) << (WIDTH - CHUNK));
         r_c      <= w_chunk_cout;
         r_idx    <= r_idx + IDX_W'(1);
`ifdef WALLACE_FA_OVF_EN
         if (w_last) begin
            r_ovf <= w_chunk_cout;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (all driven straight from registers)
   // ---------------------------------------------------------------------------
   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_product = r_result;
   assign out_tag     = r_tag;
   assign busy        = r_busy;
`ifdef WALLACE_FA_OVF_EN
   assign out_ovf     = r_ovf;
`else
   // Top-chunk carry is deliberately discarded in this build
   logic w_unused;
   assign w_unused = w_last;
`endif

endmodule

// File: tb/tb_wallace_final_adder.sv
// -----------------------------------------------------------------------------
// tb_wallace_final_adder
//
// Self-checking bench for wallace_final_adder (default parameters). Directed
// table vectors, randomized operands against a plain-arithmetic model, and
// hand-written sequences for stall, back-to-back issue, flush and reset.
// -----------------------------------------------------------------------------
module tb_wallace_final_adder;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CHUNK = 16;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned N     = WIDTH / CHUNK;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_product;
   logic [TAG_W-1:0] out_tag;
   logic             busy;
`ifdef WALLACE_FA_OVF_EN
   logic             out_ovf;
`endif

   wallace_final_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sum      (in_sum),
      .in_carry    (in_carry),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_tag     (out_tag),
      .busy        (busy)
`ifdef WALLACE_FA_OVF_EN
      ,
      .out_ovf     (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] carry;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] exp_prod;
      logic             exp_ovf;
   } vec_t;

   // Reference: unsigned add with the extra carry bit kept
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] s,
                                              input logic [WIDTH-1:0] c);
      return {1'b0, s} + {1'b0, c};
   endfunction

   task automatic chk(input string name, input logic [WIDTH-1:0] got,
                      input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair and wait for out_valid. lat counts edges from
   // the accepting edge to the edge after which out_valid is seen.
   task automatic issue(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input logic [TAG_W-1:0] t, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         step();
         w++;
      end
      chk("in_ready_wait", WIDTH'(in_ready), WIDTH'(1));
      in_sum   = s;
      in_carry = c;
      in_tag   = t;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_sum   = '0;
      in_carry = '0;
      in_tag   = '0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   vec_t vecs[5];
   int   lat;

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 4'd3,
                  64'h0000_0001_0000_0000, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 4'd5,
                  64'h0000_0000_0000_0000, 1'b1};
      vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 4'd9,
                  64'h1234_5678_9ABC_DEF0, 1'b0};
      vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 4'd15,
                  64'h0000_0000_0000_0001, 1'b1};
      vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 4'd0,
                  64'h0001_0000_0001_0000, 1'b0};

      // Reset state, checked while reset is held
      #12;
      chk("rst_out_valid", WIDTH'(out_valid), '0);
      chk("rst_out_product", out_product, '0);
      chk("rst_out_tag", WIDTH'(out_tag), '0);
      chk("rst_busy", WIDTH'(busy), '0);
`ifdef WALLACE_FA_OVF_EN
      chk("rst_out_ovf", WIDTH'(out_ovf), '0);
`endif
      step();
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

      // Directed table
      foreach (vecs[i]) begin
         issue(vecs[i].sum, vecs[i].carry, vecs[i].tag, lat);
         chk($sformatf("vec%0d_latency", i), WIDTH'(lat), WIDTH'(N + 1));
         chk($sformatf("vec%0d_product", i), out_product, vecs[i].exp_prod);
         chk($sformatf("vec%0d_tag", i), WIDTH'(out_tag), WIDTH'(vecs[i].tag));
         chk($sformatf("vec%0d_busy", i), WIDTH'(busy), WIDTH'(1));
`ifdef WALLACE_FA_OVF_EN
         chk($sformatf("vec%0d_ovf", i), WIDTH'(out_ovf), WIDTH'(vecs[i].exp_ovf));
`endif
         step();
         chk($sformatf("vec%0d_valid_drop", i), WIDTH'(out_valid), '0);
      end

      // Randomized operands against the model
      for (int k = 0; k < 24; k++) begin
         logic [WIDTH-1:0] s, c;
         logic [TAG_W-1:0] t;
         logic [WIDTH:0]   r;
         s = {$urandom(), $urandom()};
         c = {$urandom(), $urandom()};
         if (k % 4 == 0) c = c << 1;         // tree-shaped carry, bit 0 clear
         if (k % 6 == 1) s = ~c;             // long ripple: all ones before +carry
         t = TAG_W'($urandom_range(0, 15));
         r = ref_add(s, c);
         issue(s, c, t, lat);
         chk($sformatf("rnd%0d_latency", k), WIDTH'(lat), WIDTH'(N + 1));
         chk($sformatf("rnd%0d_product", k), out_product, r[WIDTH-1:0]);
         chk($sformatf("rnd%0d_tag", k), WIDTH'(out_tag), WIDTH'(t));
`ifdef WALLACE_FA_OVF_EN
         chk($sformatf("rnd%0d_ovf", k), WIDTH'(out_ovf), WIDTH'(r[WIDTH]));
`endif
         step();
      end

      // Stall: out_ready low for 10 cycles, outputs must hold
      out_ready = 1'b0;
      issue(64'h1234_5678_9ABC_DEF0, 64'h0, 4'd9, lat);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("stall%0d_valid", k), WIDTH'(out_valid), WIDTH'(1));
         chk($sformatf("stall%0d_product", k), out_product, 64'h1234_5678_9ABC_DEF0);
         chk($sformatf("stall%0d_tag", k), WIDTH'(out_tag), WIDTH'(9));
         chk($sformatf("stall%0d_in_ready", k), WIDTH'(in_ready), '0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("stall_release_valid", WIDTH'(out_valid), '0);
      chk("stall_release_in_ready", WIDTH'(in_ready), WIDTH'(1));

      // Back-to-back offers: second accepted exactly N+2 cycles after first
      begin
         int               acc[$];
         logic [WIDTH-1:0] res[$];
         logic [WIDTH:0]   ra, rb;
         bit               acc_now;
         ra = ref_add(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0000_0000_0001);
         rb = ref_add(64'h0F0F_0F0F_F0F0_F0F0, 64'h0101_0101_1010_1010);
         in_sum   = 64'hDEAD_BEEF_0000_FFFF;
         in_carry = 64'h0000_0000_0000_0001;
         in_tag   = 4'd1;
         in_valid = 1'b1;
         for (int k = 0; k < 40; k++) begin
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) res.push_back(out_product);
            step();
            if (acc_now) begin
               acc.push_back(k);
               if (acc.size() == 1) begin
                  in_sum   = 64'h0F0F_0F0F_F0F0_F0F0;
                  in_carry = 64'h0101_0101_1010_1010;
                  in_tag   = 4'd2;
               end else begin
                  in_valid = 1'b0;
               end
            end
         end
         in_valid = 1'b0;
         chk("b2b_accept_count", WIDTH'(acc.size()), WIDTH'(2));
         chk("b2b_result_count", WIDTH'(res.size()), WIDTH'(2));
         if (acc.size() >= 2)
            chk("b2b_interval", WIDTH'(acc[1] - acc[0]), WIDTH'(N + 2));
         if (res.size() >= 2) begin
            chk("b2b_product0", res[0], ra[WIDTH-1:0]);
            chk("b2b_product1", res[1], rb[WIDTH-1:0]);
         end
      end

      // Flush during the third ADD cycle
      in_sum   = 64'hFFFF_FFFF_FFFF_FFFF;
      in_carry = 64'h1;
      in_tag   = 4'd7;
      in_valid = 1'b1;
      step();                      // accept edge
      in_valid = 1'b0;
      chk("flush_busy_before", WIDTH'(busy), WIDTH'(1));
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", WIDTH'(busy), '0);
      chk("flush_in_ready", WIDTH'(in_ready), WIDTH'(1));
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            step();
         end
         chk("flush_no_valid", WIDTH'(seen), '0);
      end

      // Flush coincident with an input handshake drops the input
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_accept_busy", WIDTH'(busy), '0);
      chk("flush_accept_in_ready", WIDTH'(in_ready), WIDTH'(1));
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            step();
         end
         chk("flush_accept_no_valid", WIDTH'(seen), '0);
      end

      // Asynchronous reset during DONE
      out_ready = 1'b0;
      issue(64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, lat);
      chk("arst_pre_valid", WIDTH'(out_valid), WIDTH'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", WIDTH'(out_valid), '0);
      chk("arst_out_product", out_product, '0);
      chk("arst_out_tag", WIDTH'(out_tag), '0);
      chk("arst_busy", WIDTH'(busy), '0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("arst_in_ready", WIDTH'(in_ready), WIDTH'(1));
      chk("arst_idle_valid", WIDTH'(out_valid), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
